// File: rtl/ring_code_monitor.sv
// Decoder and integrity monitor for a one-hot ring counter: binary index, step checks, lock FSM.
// Optional saturating error counter is compiled in when RING_ERR_COUNT_EN is defined.
module ring_code_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic                 Clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [N-1:0]         ring_in,
    output logic [$clog2(N)-1:0] idx_out,
    output logic                 valid,
    output logic                 err_onehot,
    output logic                 err_seq,
    output logic                 locked,
    output logic [CNT_W-1:0]     err_count
);
    localparam int IDX_W = $clog2(N);
    localparam int GC_W  = $clog2(LOCK_CNT + 1);
    localparam logic [GC_W-1:0] LOCK_MAX = GC_W'(LOCK_CNT);

    typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

    function automatic logic is_onehot(input logic [N-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (seen) multi = 1'b1;
                else      multi = multi;
                seen = 1'b1;
            end else begin
                seen = seen;
            end
        end
        return seen & ~multi;
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = IDX_W'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
        return {v[N-2:0], v[N-1]};
    endfunction

    logic [N-1:0]     s_q, s_prev_q;
    logic             e_q, e_prev_q, have_prev_q;
    logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             err_onehot_q, err_onehot_d;
    logic             err_seq_q, err_seq_d;
    logic             locked_q, locked_d;

    logic             onehot_s, match_s, seq_bad_s, good_s;
    logic [N-1:0]     exp_s;

    // Classify the staged sample and compute the lock FSM and output updates.
    // have_prev_q low means s_q still holds the reset value rather than a real sample.
    always_comb begin
        onehot_s     = is_onehot(s_q);
        exp_s        = e_prev_q ? rotl(s_prev_q) : s_prev_q;
        match_s      = (s_q == exp_s);
        seq_bad_s    = onehot_s & ~match_s & have_prev_q & (state_q == ST_LOCKED);
        good_s       = onehot_s & ((good_cnt_q == {GC_W{1'b0}}) | match_s);
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        idx_d        = {IDX_W{1'b0}};
        valid_d      = 1'b0;
        err_onehot_d = 1'b0;
        err_seq_d    = 1'b0;
        if (have_prev_q) begin
            idx_d        = onehot_s ? encode(s_q) : {IDX_W{1'b0}};
            valid_d      = onehot_s;
            err_onehot_d = ~onehot_s;
            err_seq_d    = seq_bad_s;
            case (state_q)
                ST_UNLOCKED: begin
                    if (good_s) begin
                        if (good_cnt_q != LOCK_MAX) good_cnt_d = good_cnt_q + GC_W'(1);
                        else                        good_cnt_d = good_cnt_q;
                    end else if (onehot_s) begin
                        good_cnt_d = GC_W'(1);
                    end else begin
                        good_cnt_d = {GC_W{1'b0}};
                    end
                    if (good_cnt_d == LOCK_MAX) state_d = ST_LOCKED;
                    else                        state_d = ST_UNLOCKED;
                end
                ST_LOCKED: begin
                    if (~onehot_s | seq_bad_s) begin
                        state_d    = ST_UNLOCKED;
                        good_cnt_d = {GC_W{1'b0}};
                    end else begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = good_cnt_q;
                    end
                end
                default: begin
                    state_d    = ST_UNLOCKED;
                    good_cnt_d = {GC_W{1'b0}};
                end
            endcase
        end else begin
            state_d    = state_q;
            good_cnt_d = good_cnt_q;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Input pipeline, lock FSM state and registered outputs.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            s_q          <= {N{1'b0}};
            e_q          <= 1'b0;
            s_prev_q     <= {N{1'b0}};
            e_prev_q     <= 1'b0;
            have_prev_q  <= 1'b0;
            good_cnt_q   <= {GC_W{1'b0}};
            state_q      <= ST_UNLOCKED;
            idx_q        <= {IDX_W{1'b0}};
            valid_q      <= 1'b0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            s_q          <= ring_in;
            e_q          <= en;
            s_prev_q     <= s_q;
            e_prev_q     <= e_q;
            have_prev_q  <= 1'b1;
            good_cnt_q   <= good_cnt_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            valid_q      <= valid_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
            locked_q     <= locked_d;
        end
    end

    assign idx_out    = idx_q;
    assign valid      = valid_q;
    assign err_onehot = err_onehot_q;
    assign err_seq    = err_seq_q;
    assign locked     = locked_q;

`ifdef RING_ERR_COUNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Saturating count of error pulses; the two pulses never coincide.
    always_comb begin
        if ((err_onehot_d | err_seq_d) && (err_count_q != {CNT_W{1'b1}}))
            err_count_d = err_count_q + CNT_W'(1);
        else
            err_count_d = err_count_q;
    end

    // Error counter register.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) err_count_q <= {CNT_W{1'b0}};
        else         err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ring_code_monitor.sv
// Scoreboard bench for ring_code_monitor: directed samples push expectations, a monitor compares.
module tb_ring_code_monitor;
    logic       Clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic [3:0] ring_in = 4'b0000;
    logic [1:0] idx_out;
    logic       valid, err_onehot, err_seq, locked;
    logic [7:0] err_count;

`ifdef RING_ERR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        int due;
        int idx;
        int v;
        int eo;
        int es;
        int lk;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ring_code_monitor #(.N(4), .LOCK_CNT(4), .CNT_W(8)) dut (
        .Clk(Clk), .resetn(resetn), .en(en), .ring_in(ring_in),
        .idx_out(idx_out), .valid(valid), .err_onehot(err_onehot),
        .err_seq(err_seq), .locked(locked), .err_count(err_count)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: compare every expectation that falls due at this output update.
    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            chk("idx_out",    int'(idx_out),    cur.idx);
            chk("valid",      int'(valid),      cur.v);
            chk("err_onehot", int'(err_onehot), cur.eo);
            chk("err_seq",    int'(err_seq),    cur.es);
            chk("locked",     int'(locked),     cur.lk);
            chk("err_count",  int'(err_count),  cur.cnt);
        end
    end

    // Drive one sample (called at a falling edge) and queue its decoded response.
    task automatic step(input logic [3:0] r, input logic e, input int idx, input int v,
                        input int eo, input int es, input int lk, input int cnt);
        exp_t x;
        ring_in = r;
        en      = e;
        x.due = cyc + 2;
        x.idx = idx;
        x.v   = v;
        x.eo  = eo;
        x.es  = es;
        x.lk  = lk;
        x.cnt = CNT_ON ? cnt : 0;
        sb.push_back(x);
        @(negedge Clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_idx"},    int'(idx_out),    0);
        chk({tag, "_valid"},  int'(valid),      0);
        chk({tag, "_eoh"},    int'(err_onehot), 0);
        chk({tag, "_eseq"},   int'(err_seq),    0);
        chk({tag, "_locked"}, int'(locked),     0);
        chk({tag, "_cnt"},    int'(err_count),  0);
    endtask

    initial begin
        ring_in = 4'b0001;
        en      = 1'b0;
        repeat (3) @(negedge Clk);
        chk_zero("reset");
        resetn = 1'b1;

        // Static code: lock on the 4th good sample.
        for (int i = 0; i < 8; i++) step(4'b0001, 1'b0, 0, 1, 0, 0, (i >= 3) ? 1 : 0, 0);

        // Producer advancing, including wrap-around.
        step(4'b0001, 1'b1, 0, 1, 0, 0, 1, 0);
        step(4'b0010, 1'b1, 1, 1, 0, 0, 1, 0);
        step(4'b0100, 1'b1, 2, 1, 0, 0, 1, 0);
        step(4'b1000, 1'b1, 3, 1, 0, 0, 1, 0);
        step(4'b0001, 1'b1, 0, 1, 0, 0, 1, 0);
        step(4'b0010, 1'b0, 1, 1, 0, 0, 1, 0);

        // Non-one-hot sample while locked, then relock.
        step(4'b0110, 1'b0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1, 1, 0, 0, (i == 3) ? 1 : 0, 1);

        // Stalled producer with en=1.
        step(4'b0010, 1'b1, 1, 1, 0, 0, 1, 1);
        step(4'b0010, 1'b1, 1, 1, 0, 1, 0, 2);
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1, 1, 0, 0, (i == 3) ? 1 : 0, 2);

        // Producer moving with en=0, then an out-of-sequence restart while unlocked.
        step(4'b0100, 1'b0, 2, 1, 0, 1, 0, 3);
        step(4'b0100, 1'b0, 2, 1, 0, 0, 0, 3);
        step(4'b0100, 1'b0, 2, 1, 0, 0, 0, 3);
        step(4'b1000, 1'b0, 3, 1, 0, 0, 0, 3);
        step(4'b1000, 1'b0, 3, 1, 0, 0, 0, 3);
        step(4'b1000, 1'b0, 3, 1, 0, 0, 0, 3);
        step(4'b1000, 1'b0, 3, 1, 0, 0, 1, 3);
        drain();

        // Asynchronous reset between clock edges while locked.
        @(posedge Clk);
        #2 resetn = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge Clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 0, 1, 0, 0, (i == 3) ? 1 : 0, 0);

        // Counter saturation under a long run of invalid samples.
        for (int i = 0; i < 300; i++)
            step((i % 2 == 1) ? 4'b1111 : 4'b0000, 1'b0, 0, 0, 1, 0, 0, (i + 1 > 255) ? 255 : i + 1);
        step(4'b0001, 1'b0, 0, 1, 0, 0, 0, 255);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ring_code_monitor.md
# ring_code_monitor

Receive-side companion to the team's one-hot ring counters. It samples a ring code and the producer's advance strobe, and decodes the one-hot word to a binary index. It also checks that every step is a legal single-position rotation and keeps a lock state and an error count. It sits beside any ring-counter output, e.g. a 4-bit sequencer driving a display or phase enable, as a decoder plus an integrity monitor.

## Interface
- N, 4: ring width, N ≥ 2; producer reset code is bit 0 set (0…01).
- LOCK_CNT, 4: consecutive good samples required to assert `locked`, ≥ 1.
- CNT_W, 8: error counter width.

- Clk  in  1  rising-edge clock, same domain as the producer.
- resetn  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- en  in  1  producer advance strobe, the same signal that drives the ring counter's `en`.
- ring_in  in  N  producer ring output `q`.
- idx_out  out  $clog2(N)  binary index of the set bit; 0 when the sample is not one-hot.
- valid  out  1  sample was exactly one-hot.
- err_onehot  out  1  one-cycle pulse: sample had zero or ≥2 bits set.
- err_seq  out  1  one-cycle pulse: one-hot sample inconsistent with the previous sample and `en`.
- locked  out  1  level: sequence tracking established.
- err_count  out  CNT_W  saturating error count.

## Operation
- Input stage: at every edge, capture `s <= ring_in`, `e <= en`, `s_prev <= s`, `e_prev <= e`, `have_prev <= 1`.
- Expected value: `exp = e_prev ? rotl(s_prev) : s_prev`.
  - rotl moves bit i to bit i+1, with the MSB wrapping to bit 0, e.g. 1000 → 0001.
- One-hot check on `s`:
  - One-hot: `valid=1`, `idx_out` = position of the set bit.
  - Otherwise: `valid=0`, `idx_out=0`, `err_onehot` pulses.
- Sequence check: `err_seq` pulses when `s` is one-hot, `s != exp`, `have_prev=1` and state is LOCKED.
  - An invalid `s_prev` makes `s` fail the compare.
- Lock FSM: two states, UNLOCKED (reset state) and LOCKED.
  - A sample is good if it is one-hot and either it is the first good sample in the run or `s == exp`.
  - UNLOCKED: `good_cnt` increments on each good sample and clears on any non-good sample.
  - UNLOCKED → LOCKED when `good_cnt` reaches LOCK_CNT. `good_cnt` saturates.
  - LOCKED → UNLOCKED on any `err_onehot` or `err_seq`; `good_cnt` clears.
  - A one-hot but out-of-sequence sample in UNLOCKED restarts the run at 1; no `err_seq` is raised.
- `err_count` increments by 1 per cycle in which `err_onehot | err_seq` is asserted, in either state.
  - Saturates at 2^CNT_W−1 and never wraps.
  - `err_onehot` and `err_seq` are mutually exclusive, so there is at most +1 per cycle.
- Reset (asynchronous, any time including mid-run) clears to 0 all of the following:
  - internal registers: `s`, `e`, `s_prev`, `e_prev`, `have_prev`, `good_cnt`;
  - FSM state, which returns to UNLOCKED;
  - every output: `idx_out`, `valid`, `err_onehot`, `err_seq`, `locked`, `err_count`.

## Timing
- `ring_in` and `en` are sampled at edge k.
- `idx_out`, `valid`, the error pulses, `locked` and `err_count` reflect that sample after edge k+1, i.e. 2-cycle latency.
- A producer that advances at edge k (en=1 before edge k) is checked against the sample taken at edge k+1.
- `locked` asserts in the same output update as the decode of the LOCK_CNT-th good sample.
- `locked` deasserts in the same update as the error pulse that causes it.
- Error pulses last exactly one cycle per offending sample; back-to-back bad samples give back-to-back pulses.
- Wrap-around (MSB → bit 0) is a legal step, not an error.

## Configuration
- `RING_ERR_COUNT_EN` defined: the `err_count` register and its saturation logic are compiled in.
- Not defined: `err_count` is tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset, then hold `ring_in=0001`, `en=0` for 8 cycles: `valid=1`, `idx_out=0`, `locked` rises on the 4th good sample's update, no error pulses.
- After lock, `en=1` for 5 cycles with the producer stepping 0001→0010→0100→1000→0001: `idx_out` = 0,1,2,3,0; no `err_seq` at the wrap.
- While locked, force `ring_in=0110` for one cycle: one `err_onehot` pulse, `valid=0`, `idx_out=0`, `locked=0`, `err_count=1`. Relock after 4 good samples.
- While locked, hold `en=1` but keep `ring_in=0010` (stalled producer): `err_seq` pulse, `err_count` +1, `locked` drops. Repeat with `ring_in` advancing while `en=0`: same response.
- With CNT_W=8, inject 300 invalid samples: `err_count` stops at 255 and stays there. With the macro undefined, `err_count` stays 0.
- Assert `resetn=0` mid-sequence while locked with `err_count=3`: all outputs read 0 immediately without waiting for a clock edge; after release the monitor is UNLOCKED and needs 4 good samples to relock.
